vc_test_mem_copy_engine: RTL and testbench
==========================================

Name: vc_test_mem_copy_engine

Overview:
- Word-granular memory copy initiator. It is the requester end of the memreq/memresp val/rdy protocol served by the test memory ports.
- On a go command it copies go_count data words from go_src to go_dst. Each word is a read request, its response, a write request carrying the read data, then the write response.
- One request is outstanding at a time, so it works against any responder latency or response queueing.
- Used in test harnesses and as a simple DMA stand-in for memory-system stress tests.

Parameters:
- p_addr_sz, 8, mem message address width in bits
- p_data_sz, 32, mem message data width in bits; must be a multiple of 8
- p_count_sz, 8, width of the word-count field
- c_len_sz, $clog2(p_data_sz/8), derived: mem message len field width
- c_req_msg_sz, 3+p_addr_sz+c_len_sz+p_data_sz, derived: request message width
- c_resp_msg_sz, 3+c_len_sz+p_data_sz, derived: response message width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- go_val  in  1  copy command valid
- go_rdy  out  1  engine idle and able to accept a command
- go_src  in  p_addr_sz  source byte address
- go_dst  in  p_addr_sz  destination byte address
- go_count  in  p_count_sz  number of words to copy
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse when a copy completes
- err  out  1  sticky response-type error flag
- memreq_val  out  1  request valid
- memreq_rdy  in  1  request ready
- memreq_msg  out  c_req_msg_sz  request message
- memresp_val  in  1  response valid
- memresp_rdy  out  1  response ready
- memresp_msg  in  c_resp_msg_sz  response message

Behaviour:
- Message formats:
  - Request, MSB to LSB: type[3], addr, len, data.
  - Response, MSB to LSB: type[3], len, data.
  - Type codes: read=0, write=1, amoadd=2, amoand=3, amoor=4, amoxch=5.
  - The engine issues only read and write, always with len=0 (full word).
- Reset state:
  - State is IDLE.
  - go_rdy=1; busy=0, done=0, err=0, memreq_val=0, memresp_rdy=1.
  - Reset mid-copy abandons the copy immediately with no done pulse.
- FSM states and transitions:
  - IDLE: go_rdy=1 and memresp_rdy=1. Stray responses are accepted and discarded without setting err. On go_val: latch src, dst, remaining=go_count, and clear err. If go_count==0, go to DONE, else go to RD_REQ.
  - RD_REQ: memreq_val=1 with {read, src, 0, 0}. On memreq_val && memreq_rdy, go to RD_WAIT.
  - RD_WAIT: memresp_rdy=1. On memresp_val:
    - latch the data field into the word register;
    - if the type is not read, set err;
    - go to WR_REQ.
  - WR_REQ: memreq_val=1 with {write, dst, 0, word}. On fire, go to WR_WAIT.
  - WR_WAIT: memresp_rdy=1. On memresp_val:
    - if the type is not write, set err;
    - src += p_data_sz/8, dst += p_data_sz/8;
    - remaining -= 1;
    - go to DONE if remaining was 1, else go to RD_REQ.
  - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- busy=1 in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT; busy=0 in IDLE and DONE.
- memresp_rdy=0 in RD_REQ, WR_REQ and DONE. memreq_val=0 outside RD_REQ and WR_REQ.
- memreq_msg must stay stable while memreq_val=1 and memreq_rdy=0.
- The engine does not drop memreq_val once asserted until the request fires.
- Throughput limits:
  - Minimum 4 cycles per word (req fire, resp, req fire, resp), assuming a zero-wait responder.
  - A response is never consumed in the same cycle its request fires.
- Address arithmetic is modulo 2^p_addr_sz: increments wrap silently, with no error.
- Overlapping src/dst ranges are copied strictly in ascending word order; overlap is not detected.
- go_val while busy is ignored because go_rdy=0; there is no queueing of commands.
- err is valid from the DONE cycle onward and holds until the next accepted go.
- A copy continues to completion after an error.
- Assertions: go_val, memreq_rdy and memresp_val must never be X at posedge clk.

Test Plan:
- Single word: p_data_sz=32, mem[0x10]=0xDEADBEEF; go src=0x10, dst=0x40, count=1.
  - Requires exactly the requests {read,0x10,0,0} then {write,0x40,0,0xDEADBEEF}.
  - done pulses once and err=0.
- Multi-word with stalls: count=4, src=0x00, dst=0x80, responder adds random 0-3 cycle delays on rdy and val.
  - mem[0x80..0x8C] equals mem[0x00..0x0C].
  - Read addresses are 0x00,0x04,0x08,0x0C.
  - memreq_msg is stable during every stall.
- Zero count: go count=0.
  - No memreq_val is ever asserted.
  - done pulses on the cycle after go, and busy is never 1.
- Address wrap: p_addr_sz=8, src=0xF8, dst=0x20, count=3.
  - Read addresses are 0xF8, 0xFC, 0x00.
  - Write addresses are 0x20, 0x24, 0x28.
- Error and reset cases:
  - Injected write-typed response in RD_WAIT: err=1 at done and held until the next go; the next clean copy leaves err=0.
  - reset asserted during WR_REQ: the next cycle has memreq_val=0, busy=0 and no done pulse.
  - A late response arriving in IDLE is drained, leaving err=0.

Source files
------------

// File: rtl/vc_test_mem_copy_engine.sv
// Word-granular memory copy initiator on the memreq/memresp val/rdy protocol.
// One request is outstanding at a time: read a word, write it back, repeat.
module vc_test_mem_copy_engine #(
   parameter int p_addr_sz     = 8,
   parameter int p_data_sz     = 32,
   parameter int p_count_sz    = 8,
   parameter int c_len_sz      = $clog2(p_data_sz/8),
   parameter int c_req_msg_sz  = 3+p_addr_sz+c_len_sz+p_data_sz,
   parameter int c_resp_msg_sz = 3+c_len_sz+p_data_sz
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     go_val,
   output logic                     go_rdy,
   input  logic [p_addr_sz-1:0]     go_src,
   input  logic [p_addr_sz-1:0]     go_dst,
   input  logic [p_count_sz-1:0]    go_count,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     memreq_val,
   input  logic                     memreq_rdy,
   output logic [c_req_msg_sz-1:0]  memreq_msg,
   input  logic                     memresp_val,
   output logic                     memresp_rdy,
   input  logic [c_resp_msg_sz-1:0] memresp_msg
);

   localparam logic [2:0]           c_type_read  = 3'd0;
   localparam logic [2:0]           c_type_write = 3'd1;
   localparam logic [p_addr_sz-1:0] c_stride     = p_addr_sz'(p_data_sz/8);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

   state_t                 state, state_n;
   logic [p_addr_sz-1:0]   src_q, dst_q;
   logic [p_count_sz-1:0]  rem_q;
   logic [p_data_sz-1:0]   word_q;
   logic                   err_q;

   logic [2:0]             req_type;
   logic [p_addr_sz-1:0]   req_addr;
   logic [p_data_sz-1:0]   req_data;
   logic [2:0]             resp_type;
   logic [p_data_sz-1:0]   resp_data;
   logic                   unused_resp_len;

   assign resp_type       = memresp_msg[c_resp_msg_sz-1 -: 3];
   assign resp_data       = memresp_msg[p_data_sz-1:0];
   assign unused_resp_len = ^memresp_msg[p_data_sz +: c_len_sz];

   // Length is always zero: the engine only moves full words.
   assign memreq_msg = {req_type, req_addr, {c_len_sz{1'b0}}, req_data};
   assign err        = err_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n     = state;
      go_rdy      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      memreq_val  = 1'b0;
      memresp_rdy = 1'b0;
      req_type    = c_type_read;
      req_addr    = src_q;
      req_data    = '0;
      case (state)
         IDLE: begin
            go_rdy      = 1'b1;
            memresp_rdy = 1'b1;   // stray responses are drained here
            if (go_val) state_n = (go_count == '0) ? DONE : RD_REQ;
         end
         RD_REQ: begin
            busy       = 1'b1;
            memreq_val = 1'b1;
            if (memreq_rdy) state_n = RD_WAIT;
         end
         RD_WAIT: begin
            busy        = 1'b1;
            memresp_rdy = 1'b1;
            if (memresp_val) state_n = WR_REQ;
         end
         WR_REQ: begin
            busy       = 1'b1;
            memreq_val = 1'b1;
            req_type   = c_type_write;
            req_addr   = dst_q;
            req_data   = word_q;
            if (memreq_rdy) state_n = WR_WAIT;
         end
         WR_WAIT: begin
            busy        = 1'b1;
            memresp_rdy = 1'b1;
            if (memresp_val) state_n = (rem_q == p_count_sz'(1)) ? DONE : RD_REQ;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q  <= '0;
         dst_q  <= '0;
         rem_q  <= '0;
         word_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (go_val) begin
               src_q <= go_src;
               dst_q <= go_dst;
               rem_q <= go_count;
               err_q <= 1'b0;
            end
            RD_WAIT: if (memresp_val) begin
               word_q <= resp_data;
               if (resp_type != c_type_read) err_q <= 1'b1;
            end
            WR_WAIT: if (memresp_val) begin
               if (resp_type != c_type_write) err_q <= 1'b1;
               src_q <= src_q + c_stride;
               dst_q <= dst_q + c_stride;
               rem_q <= rem_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!$isunknown(go_val));
         assert (!$isunknown(memreq_rdy));
         assert (!$isunknown(memresp_val));
      end
   end

endmodule

// File: tb/tb_vc_test_mem_copy_engine.sv
// Scoreboarded bench: a memory responder model serves the engine, a monitor
// checks every fired request against the expected copy sequence.
module tb_vc_test_mem_copy_engine;

   localparam int AW = 8, DW = 32, CW = 8, REQW = 45, RESPW = 37;

   logic            clk = 1'b0, reset = 1'b1;
   logic            go_val = 1'b0, go_rdy;
   logic [AW-1:0]   go_src = '0, go_dst = '0;
   logic [CW-1:0]   go_count = '0;
   logic            busy, done, err;
   logic            memreq_val, memreq_rdy = 1'b0;
   logic [REQW-1:0] memreq_msg;
   logic            memresp_val = 1'b0, memresp_rdy;
   logic [RESPW-1:0] memresp_msg = '0;

   always #5 clk = ~clk;

   vc_test_mem_copy_engine #(.p_addr_sz(AW), .p_data_sz(DW), .p_count_sz(CW)) dut (
      .clk(clk), .reset(reset),
      .go_val(go_val), .go_rdy(go_rdy), .go_src(go_src), .go_dst(go_dst), .go_count(go_count),
      .busy(busy), .done(done), .err(err),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
   );

   typedef struct { logic [RESPW-1:0] msg; int t; } resp_t;

   logic [31:0]     mem [64];
   logic [31:0]     ref_mem [64];
   logic [REQW-1:0] exp_req [$];
   resp_t           rq [$];
   int cyc = 0;
   int tests = 0, fails = 0;
   int inj_cnt = 0, inj_used = 0, stray_cnt = 0, stray_used = 0;
   int busy_cycles = 0, req_cycles = 0;
   bit stall_en = 0, hold_wr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // memory responder: decides rdy/val at negedge, so handshakes land on the next posedge
   always @(negedge clk) begin
      logic [2:0]       typ;
      logic [7:0]       a;
      logic [RESPW-1:0] rmsg;
      if (reset) begin
         rq.delete();
         memreq_rdy  = 1'b0;
         memresp_val = 1'b0;
      end else begin
         memreq_rdy = (!stall_en || $urandom_range(0, 1) == 1) &&
                      !(hold_wr && memreq_val && memreq_msg[REQW-1 -: 3] == 3'd1);
         if (memreq_val && memreq_rdy) begin
            typ = memreq_msg[REQW-1 -: 3];
            a   = memreq_msg[REQW-4 -: 8];
            if (typ == 3'd1) begin
               mem[a[7:2]] = memreq_msg[31:0];
               rmsg = {3'd1, 2'd0, 32'd0};
            end else begin
               rmsg = {3'd0, 2'd0, mem[a[7:2]]};
               if (inj_used < inj_cnt) begin
                  rmsg[RESPW-1 -: 3] = 3'd1;
                  inj_used++;
               end
            end
            rq.push_back('{rmsg, cyc + 1 + (stall_en ? int'($urandom_range(0, 3)) : 0)});
         end
         if (stray_used < stray_cnt) begin
            memresp_val = 1'b1;
            memresp_msg = {3'd1, 2'd0, 32'hBAD0BAD0};
            stray_used++;
         end else if (rq.size() > 0 && rq[0].t <= cyc) begin
            memresp_val = 1'b1;
            memresp_msg = rq[0].msg;
            if (memresp_rdy) void'(rq.pop_front());
         end else begin
            memresp_val = 1'b0;
         end
      end
   end

   // monitor: request order/content and stall stability
   logic [REQW-1:0] prev_msg = '0;
   bit              prev_stall = 0;
   always begin
      logic [REQW-1:0] e;
      @(negedge clk); #1;
      if (!reset) begin
         if (busy) busy_cycles++;
         if (memreq_val) req_cycles++;
         if (prev_stall) begin
            tests++;
            if (!memreq_val || memreq_msg !== prev_msg) begin
               fails++;
               $display("FAIL req_stable got val=%b msg=%h exp val=1 msg=%h", memreq_val, memreq_msg, prev_msg);
            end
         end
         if (memreq_val && memreq_rdy) begin
            tests++;
            if (exp_req.size() == 0) begin
               fails++;
               $display("FAIL req_unexpected got=%h exp=none", memreq_msg);
            end else begin
               e = exp_req.pop_front();
               if (memreq_msg !== e) begin
                  fails++;
                  $display("FAIL req_msg got=%h exp=%h", memreq_msg, e);
               end
            end
         end
         prev_stall = memreq_val && !memreq_rdy;
         prev_msg   = memreq_msg;
      end else begin
         prev_stall = 0;
      end
   end

   task automatic tick();
      @(negedge clk); #2;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic chk_mem(input string nm);
      int bad = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk(nm, bad, 0);
   endtask

   // reference model: a copy is a list of word reads then writes in ascending order
   task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
      for (int i = 0; i < int'(n); i++) begin
         logic [7:0] ra, wa;
         ra = s + 8'(4*i);
         wa = d + 8'(4*i);
         exp_req.push_back({3'd0, ra, 2'd0, 32'd0});
         exp_req.push_back({3'd1, wa, 2'd0, ref_mem[ra[7:2]]});
         ref_mem[wa[7:2]] = ref_mem[ra[7:2]];
      end
      chk("go_rdy_before_go", go_rdy, 1);
      go_val = 1'b1; go_src = s; go_dst = d; go_count = n;
      tick();
      go_val = 1'b0;
   endtask

   task automatic wait_done(input logic exp_err, input string nm, output int lat);
      lat = 0;
      while (!done && lat < 2000) begin tick(); lat++; end
      chk({nm, "_done_seen"}, done, 1);
      chk({nm, "_err"}, err, exp_err);
      chk({nm, "_busy_at_done"}, busy, 0);
      tick();
      chk({nm, "_done_one_cycle"}, done, 0);
      chk({nm, "_idle_after"}, go_rdy, 1);
      chk({nm, "_reqs_left"}, exp_req.size(), 0);
   endtask

   initial begin
      int lat, b0, r0, k;
      logic [7:0] s, d, n;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[4'h4] = 32'hDEADBEEF;
      ref_mem = mem;

      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_go_rdy", go_rdy, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_memreq_val", memreq_val, 0);
      chk("rst_memresp_rdy", memresp_rdy, 1);

      start_copy(8'h10, 8'h40, 8'd1);
      wait_done(1'b0, "single", lat);
      chk("single_dst_word", mem[8'h40 >> 2], 32'hDEADBEEF);
      chk_mem("single_mem");

      stall_en = 1;
      start_copy(8'h00, 8'h80, 8'd4);
      wait_done(1'b0, "multi", lat);
      chk_mem("multi_mem");
      stall_en = 0;

      b0 = busy_cycles; r0 = req_cycles;
      start_copy(8'h30, 8'h50, 8'd0);
      wait_done(1'b0, "zero", lat);
      chk("zero_done_latency", lat, 0);
      repeat (2) tick();
      chk("zero_busy_never", busy_cycles - b0, 0);
      chk("zero_req_never", req_cycles - r0, 0);

      start_copy(8'hF8, 8'h20, 8'd3);
      wait_done(1'b0, "wrap", lat);
      chk_mem("wrap_mem");

      inj_cnt++;
      start_copy(8'h00, 8'h60, 8'd2);
      wait_done(1'b1, "err", lat);
      repeat (5) tick();
      chk("err_held_idle", err, 1);
      start_copy(8'h10, 8'h70, 8'd1);
      chk("err_cleared_on_go", err, 0);
      wait_done(1'b0, "clean_after_err", lat);
      chk_mem("clean_after_err_mem");

      stray_cnt++;
      repeat (4) tick();
      chk("stray_err", err, 0);
      chk("stray_go_rdy", go_rdy, 1);
      chk("stray_busy", busy, 0);

      hold_wr = 1;
      start_copy(8'h20, 8'h90, 8'd2);
      k = 0;
      while (!(memreq_val && memreq_msg[REQW-1 -: 3] == 3'd1) && k < 200) begin tick(); k++; end
      chk("rst_mid_reach_wr_req", memreq_val, 1);
      reset = 1'b1;
      tick();
      chk("rst_mid_memreq_val", memreq_val, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      reset = 1'b0;
      hold_wr = 0;
      exp_req.delete();
      ref_mem = mem;
      tick();
      chk("rst_mid_no_done_later", done, 0);
      chk("rst_mid_err", err, 0);
      stall_en = 1;
      start_copy(8'h20, 8'h90, 8'd2);
      wait_done(1'b0, "after_rst", lat);
      chk_mem("after_rst_mem");

      for (int t = 0; t < 8; t++) begin
         stall_en = ($urandom_range(0, 1) == 1);
         s = 8'($urandom) & 8'hFC;
         d = 8'($urandom) & 8'hFC;
         n = 8'($urandom_range(1, 6));
         start_copy(s, d, n);
         wait_done(1'b0, "rand", lat);
         chk_mem("rand_mem");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
